// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - derives J/K excitations for a goal state and applies them to a JK bank
module jk_excitation_driver #(
  parameter int WIDTH     = 4,
  parameter int DC_POLICY = 0,
  parameter int CNT_W     = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] J_out,
  output logic [WIDTH-1:0] K_out,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             done,
  output logic             match,
  output logic [CNT_W-1:0] toggle_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ENCODE = 2'd1;
  localparam logic [1:0] APPLY  = 2'd2;
  localparam logic [1:0] CHECK  = 2'd3;

  localparam logic [1:0] M_LOAD = 2'd0;
  localparam logic [1:0] M_INCR = 2'd1;
  localparam logic [1:0] M_DECR = 2'd2;

  // Popcount of a WIDTH<=16 vector fits in 5 extra bits above the counter.
  localparam int SUM_W = CNT_W + 5;

  localparam logic [WIDTH-1:0] DC_VEC  = (DC_POLICY != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] goal;
  logic [WIDTH-1:0] goal_next;
  logic [WIDTH-1:0] j_next;
  logic [WIDTH-1:0] k_next;
  logic [WIDTH-1:0] q_next;
  logic [SUM_W-1:0] toggle_sum;

  assign in_ready = (state == IDLE);
  assign Q_bar    = ~Q;

  // Goal state for the latched request, taken from the bank's current contents.
  always_comb begin
    goal_next = Q;
    case (mode_q)
      M_LOAD:  goal_next = target_q;
      M_INCR:  goal_next = Q + WIDTH'(1);
      M_DECR:  goal_next = Q - WIDTH'(1);
      default: goal_next = Q;
    endcase
  end

  // Inverse JK table: a 0 bit only needs J, a 1 bit only needs K; the other input is don't-care.
  always_comb begin
    j_next = (~Q & goal_next) | (Q & DC_VEC);
    k_next = (Q & ~goal_next) | (~Q & DC_VEC);
    if (mode_q == 2'b11) begin
      j_next = '0;
      k_next = '0;
    end
  end

  // JK bank response plus the saturating toggle tally for this application.
  always_comb begin
    q_next     = (J_out & ~Q) | (~K_out & Q);
    toggle_sum = {5'b0, toggle_count};
    for (int i = 0; i < WIDTH; i++) begin
      toggle_sum = toggle_sum + SUM_W'(J_out[i] & K_out[i]);
    end
  end

  // Sequencer: fixed four-cycle walk once a request is accepted.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state <= ENCODE;
        ENCODE:  state <= APPLY;
        APPLY:   state <= CHECK;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: request capture, excitation registers, JK bank, result flags and statistics.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mode_q       <= '0;
      target_q     <= '0;
      goal         <= '0;
      J_out        <= '0;
      K_out        <= '0;
      Q            <= '0;
      done         <= 1'b0;
      match        <= 1'b0;
      toggle_count <= '0;
      err_count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q   <= mode;
            target_q <= target;
          end
        end
        ENCODE: begin
          goal  <= goal_next;
          J_out <= j_next;
          K_out <= k_next;
        end
        APPLY: begin
          Q     <= q_next;
          done  <= 1'b1;
          match <= (q_next == goal);
          if (toggle_sum > SUM_W'(CNT_MAX)) toggle_count <= CNT_MAX;
          else                              toggle_count <= toggle_sum[CNT_W-1:0];
        end
        default: begin
          if (!match && err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - randomized and directed checks of jk_excitation_driver against a reference model
module tb_jk_excitation_driver;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] target = 4'd0;

  logic [3:0] jo [3];
  logic [3:0] ko [3];
  logic [3:0] qo [3];
  logic [3:0] qbo [3];
  logic       dn [3];
  logic       mt [3];
  logic       rdy [3];
  logic [7:0] tc [3];
  logic [7:0] ec [3];
  logic [1:0] tc2;
  logic [1:0] ec2;

  assign tc[2] = {6'b0, tc2};
  assign ec[2] = {6'b0, ec2};

  jk_excitation_driver #(.WIDTH(4), .DC_POLICY(0), .CNT_W(8)) dut0 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(rdy[0]), .mode(mode), .target(target),
    .J_out(jo[0]), .K_out(ko[0]), .Q(qo[0]), .Q_bar(qbo[0]), .done(dn[0]), .match(mt[0]),
    .toggle_count(tc[0]), .err_count(ec[0]));

  jk_excitation_driver #(.WIDTH(4), .DC_POLICY(1), .CNT_W(8)) dut1 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(rdy[1]), .mode(mode), .target(target),
    .J_out(jo[1]), .K_out(ko[1]), .Q(qo[1]), .Q_bar(qbo[1]), .done(dn[1]), .match(mt[1]),
    .toggle_count(tc[1]), .err_count(ec[1]));

  jk_excitation_driver #(.WIDTH(4), .DC_POLICY(1), .CNT_W(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(rdy[2]), .mode(mode), .target(target),
    .J_out(jo[2]), .K_out(ko[2]), .Q(qo[2]), .Q_bar(qbo[2]), .done(dn[2]), .match(mt[2]),
    .toggle_count(tc2), .err_count(ec2));

  always #5 Clock = ~Clock;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] m_q;
  int         m_tc [3];
  int         dcp  [3] = '{0, 1, 1};
  int         tmax [3] = '{255, 255, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Excitation table written out bit by bit, with the don't-care resolved by policy.
  task automatic model_exc(input logic [3:0] q, input logic [3:0] g, input int dc, input bit hold,
                           output logic [3:0] j, output logic [3:0] k);
    for (int i = 0; i < 4; i++) begin
      if (hold) begin
        j[i] = 1'b0; k[i] = 1'b0;
      end else if (q[i] == 1'b0) begin
        j[i] = g[i]; k[i] = (dc != 0);
      end else begin
        j[i] = (dc != 0); k[i] = ~g[i];
      end
    end
  endtask

  function automatic logic [3:0] model_goal(input logic [1:0] md, input logic [3:0] q, input logic [3:0] tg);
    case (md)
      2'd0:    return tg;
      2'd1:    return q + 4'd1;
      2'd2:    return q - 4'd1;
      default: return q;
    endcase
  endfunction

  task automatic count_toggles(input logic [3:0] q, input logic [3:0] g, input bit hold);
    logic [3:0] j, k;
    int s;
    for (int p = 0; p < 3; p++) begin
      model_exc(q, g, dcp[p], hold, j, k);
      s = m_tc[p] + $countones(j & k);
      m_tc[p] = (s > tmax[p]) ? tmax[p] : s;
    end
  endtask

  task automatic do_req(input logic [1:0] md, input logic [3:0] tg);
    logic [3:0] g, gb;
    logic [3:0] ej [3];
    logic [3:0] ek [3];
    int waited;
    @(negedge Clock);
    in_valid = 1'b1; mode = md; target = tg;
    waited = 0;
    while (!rdy[0] && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    chk("ready_wait", 32'(rdy[0]), 32'd1);
    g  = model_goal(md, m_q, tg);
    gb = ~g;
    @(negedge Clock);
    in_valid = 1'b0; mode = 2'($urandom); target = 4'($urandom);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("encode_ready[%0d]", p), 32'(rdy[p]), 32'd0);
      chk($sformatf("encode_done[%0d]", p), 32'(dn[p]), 32'd0);
    end
    @(negedge Clock);
    for (int p = 0; p < 3; p++) begin
      model_exc(m_q, g, dcp[p], md == 2'd3, ej[p], ek[p]);
      chk($sformatf("J_out[%0d]", p), 32'(jo[p]), 32'(ej[p]));
      chk($sformatf("K_out[%0d]", p), 32'(ko[p]), 32'(ek[p]));
      chk($sformatf("apply_done[%0d]", p), 32'(dn[p]), 32'd0);
    end
    count_toggles(m_q, g, md == 2'd3);
    @(negedge Clock);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("done[%0d]", p), 32'(dn[p]), 32'd1);
      chk($sformatf("match[%0d]", p), 32'(mt[p]), 32'd1);
      chk($sformatf("Q[%0d]", p), 32'(qo[p]), 32'(g));
      chk($sformatf("Q_bar[%0d]", p), 32'(qbo[p]), 32'(gb));
      chk($sformatf("toggle_count[%0d]", p), 32'(tc[p]), 32'(m_tc[p]));
      chk($sformatf("err_count[%0d]", p), 32'(ec[p]), 32'd0);
    end
    @(negedge Clock);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("post_done[%0d]", p), 32'(dn[p]), 32'd0);
      chk($sformatf("post_ready[%0d]", p), 32'(rdy[p]), 32'd1);
      chk($sformatf("match_hold[%0d]", p), 32'(mt[p]), 32'd1);
    end
    m_q = g;
  endtask

  task automatic check_reset_state(input string tag);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("%s_Q[%0d]", tag, p), 32'(qo[p]), 32'd0);
      chk($sformatf("%s_Q_bar[%0d]", tag, p), 32'(qbo[p]), 32'hf);
      chk($sformatf("%s_J[%0d]", tag, p), 32'(jo[p]), 32'd0);
      chk($sformatf("%s_K[%0d]", tag, p), 32'(ko[p]), 32'd0);
      chk($sformatf("%s_done[%0d]", tag, p), 32'(dn[p]), 32'd0);
      chk($sformatf("%s_match[%0d]", tag, p), 32'(mt[p]), 32'd0);
      chk($sformatf("%s_tc[%0d]", tag, p), 32'(tc[p]), 32'd0);
      chk($sformatf("%s_ec[%0d]", tag, p), 32'(ec[p]), 32'd0);
    end
  endtask

  initial begin
    m_q = 4'd0;
    for (int p = 0; p < 3; p++) m_tc[p] = 0;

    // Reset state
    repeat (3) @(negedge Clock);
    check_reset_state("reset");
    Reset = 1'b0;
    @(negedge Clock);
    chk("ready_after_reset", 32'(rdy[0]), 32'd1);

    // Pacing: in_valid held high across four INCR requests from zero
    in_valid = 1'b1; mode = 2'd1; target = 4'd0;
    for (int c = 0; c < 16; c++) begin
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("pace_ready[%0d]c%0d", p, c), 32'(rdy[p]), 32'(c % 4 == 0));
        chk($sformatf("pace_done[%0d]c%0d", p, c), 32'(dn[p]), 32'(c % 4 == 3));
      end
      if (c % 4 == 3) begin
        count_toggles(m_q, m_q + 4'd1, 1'b0);
        m_q = m_q + 4'd1;
        for (int p = 0; p < 3; p++) begin
          chk($sformatf("pace_Q[%0d]c%0d", p, c), 32'(qo[p]), 32'(m_q));
          chk($sformatf("pace_tc[%0d]c%0d", p, c), 32'(tc[p]), 32'(m_tc[p]));
        end
      end
      if (c == 13) in_valid = 1'b0;
      @(negedge Clock);
    end

    // Directed: LOAD patterns, wraps, HOLD
    do_req(2'd0, 4'b1010);
    do_req(2'd0, 4'b0101);
    do_req(2'd0, 4'b1111);
    do_req(2'd1, 4'b0000);
    do_req(2'd2, 4'b0000);
    do_req(2'd0, 4'b0110);
    do_req(2'd3, 4'b1001);

    // Reset during APPLY
    @(negedge Clock);
    in_valid = 1'b1; mode = 2'd0; target = 4'b1001;
    @(negedge Clock);
    in_valid = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check_reset_state("mid_reset");
    m_q = 4'd0;
    for (int p = 0; p < 3; p++) m_tc[p] = 0;
    @(negedge Clock);
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("abort_done[%0d]c%0d", p, c), 32'(dn[p]), 32'd0);
        chk($sformatf("abort_ready[%0d]c%0d", p, c), 32'(rdy[p]), 32'd1);
        chk($sformatf("abort_Q[%0d]c%0d", p, c), 32'(qo[p]), 32'd0);
      end
    end

    // Randomized requests
    for (int n = 0; n < 24; n++) begin
      do_req(2'($urandom_range(0, 3)), 4'($urandom));
    end

    // Saturation: alternating full-width loads toggle every bit under DC_POLICY=1
    for (int n = 0; n < 4; n++) begin
      do_req(2'd0, (n % 2 == 0) ? 4'b1111 : 4'b0000);
    end
    chk("saturated_tc2", 32'(tc[2]), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
